// File: rtl/sdpram_pkg.sv
// Shared types and helpers for the byte-enable simple dual-port RAM.
// Pulled in by the interface, the storage core and the top level.
package sdpram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sdpram_be_if.sv
// Write/read request bus of sdpram_be.
// The master side issues requests and the slave side (the RAM) returns read data.
interface sdpram_be_if
    import sdpram_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 32,
    parameter int BYTE_W = 8
) ();

    localparam int AW  = addr_w(DEPTH);
    localparam int NBE = WIDTH / BYTE_W;

    logic             wenc;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [NBE-1:0]   wbe;
    logic             renc;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;

    modport master (
        output wenc, waddr, wdata, wbe, renc, raddr,
        input  rdata, rvalid
    );

    modport slave (
        input  wenc, waddr, wdata, wbe, renc, raddr,
        output rdata, rvalid
    );

endinterface

// File: rtl/sdpram_be_core.sv
// Bare storage array with a per-lane write and an unregistered (asynchronous) read.
// The caller is responsible for range-checking addresses before using them here.
module sdpram_be_core
    import sdpram_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int WIDTH  = 32,
    parameter  int BYTE_W = 8,
    localparam int AW     = addr_w(DEPTH),
    localparam int NBE    = WIDTH / BYTE_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NBE-1:0]   wbe,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rword
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBE; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rword = mem[raddr];

endmodule

// File: rtl/sdpram_be.sv
// Single-clock simple dual-port RAM with byte enables, write-first forwarding,
// a 1- or 2-cycle read pipeline and a post-reset sweep that loads INIT_VAL everywhere.
module sdpram_be
    import sdpram_pkg::*;
#(
    parameter int               DEPTH      = 16,
    parameter int               WIDTH      = 32,
    parameter int               BYTE_W     = 8,
    parameter int               RD_LATENCY = 1,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       init_busy,
    sdpram_be_if.slave bus
);

    localparam int            AW      = addr_w(DEPTH);
    localparam int            NBE     = WIDTH / BYTE_W;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sdpram_be: RD_LATENCY must be 1 or 2");
    end
    if (WIDTH % BYTE_W != 0) begin : g_bad_width
        $error("sdpram_be: WIDTH must be a multiple of BYTE_W");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sdpram_be: DEPTH must be at least 2");
    end

    state_t        state;
    logic [AW-1:0] init_cnt;

    // The counter parks on the last word so it never wraps past DEPTH-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == LAST) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end else begin
                        init_cnt  <= init_cnt + 1'b1;
                    end
                end
                READY: begin
                    init_busy <= 1'b0;
                end
                default: begin
                    state     <= INIT;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    logic             ready;
    logic             wr_ok;
    logic             rd_in_range;
    logic             rd_accept;
    logic             core_we;
    logic [AW-1:0]    core_waddr;
    logic [WIDTH-1:0] core_wdata;
    logic [NBE-1:0]   core_wbe;
    logic [WIDTH-1:0] core_rword;
    logic [WIDTH-1:0] rd_word;

    assign ready       = (state == READY);
    assign wr_ok       = ready && bus.wenc && ({1'b0, bus.waddr} < DEPTH_W);
    assign rd_in_range = ({1'b0, bus.raddr} < DEPTH_W);
    assign rd_accept   = ready && bus.renc;

    always_comb begin
        core_we    = 1'b0;
        core_waddr = bus.waddr;
        core_wdata = bus.wdata;
        core_wbe   = bus.wbe;
        if (rst_n) begin
            if (!ready) begin
                core_we    = 1'b1;
                core_waddr = init_cnt;
                core_wdata = INIT_VAL;
                core_wbe   = '1;
            end else begin
                core_we    = wr_ok;
            end
        end
    end

    sdpram_be_core #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .BYTE_W (BYTE_W)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .wbe   (core_wbe),
        .raddr (bus.raddr),
        .rword (core_rword)
    );

    // Write-first: a same-cycle write to the read address is merged lane by lane.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            for (int i = 0; i < NBE; i++) begin
                if (wr_ok && (bus.waddr == bus.raddr) && bus.wbe[i]) begin
                    rd_word[i*BYTE_W +: BYTE_W] = bus.wdata[i*BYTE_W +: BYTE_W];
                end else begin
                    rd_word[i*BYTE_W +: BYTE_W] = core_rword[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_data <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                bus.rvalid <= 1'b0;
                bus.rdata  <= '0;
            end else begin
                bus.rvalid <= s1_valid;
                if (s1_valid) begin
                    bus.rdata <= s1_data;
                end
            end
        end
    end else begin : g_lat1
        assign bus.rvalid = s1_valid;
        assign bus.rdata  = s1_data;
    end

endmodule

// File: tb/tb_sdpram_be.sv
// Randomised scoreboard bench for sdpram_be: a 16-word latency-1 instance and a
// 12-word latency-2 instance see identical stimulus and are checked against an array model.
module tb_sdpram_be;

    localparam int          DA = 16;
    localparam int          DB = 12;
    localparam logic [31:0] IVB = 32'hA5A5_0F0F;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy_a;
    logic busy_b;
    int   edge_no;

    sdpram_be_if #(.DEPTH(DA), .WIDTH(32), .BYTE_W(8)) ifa ();
    sdpram_be_if #(.DEPTH(DB), .WIDTH(32), .BYTE_W(8)) ifb ();

    sdpram_be #(
        .DEPTH(DA), .WIDTH(32), .BYTE_W(8), .RD_LATENCY(1), .INIT_VAL(32'h0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .init_busy(busy_a), .bus(ifa)
    );

    sdpram_be #(
        .DEPTH(DB), .WIDTH(32), .BYTE_W(8), .RD_LATENCY(2), .INIT_VAL(IVB)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .init_busy(busy_b), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    // Reference model: word arrays per instance, write-first semantics.
    int          depth_m [2] = '{DA, DB};
    int          lat_m   [2] = '{1, 2};
    logic [31:0] initv_m [2] = '{32'h0, IVB};
    logic [31:0] mem_m   [2][16];
    int          init_left [2] = '{DA, DB};
    logic        exp_busy  [2] = '{1'b1, 1'b1};
    logic [31:0] last_rd   [2] = '{32'h0, 32'h0};
    exp_t        sb [2][$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model(input int k, input bit rs, input bit we, input logic [3:0] wa,
                         input logic [31:0] wd, input logic [3:0] be, input bit re,
                         input logic [3:0] ra);
        exp_t e;
        if (!rs) begin
            sb[k].delete();
            for (int a = 0; a < 16; a++) mem_m[k][a] = initv_m[k];
            init_left[k] = depth_m[k];
            exp_busy[k]  = 1'b1;
        end else if (init_left[k] > 0) begin
            init_left[k]--;
            exp_busy[k] = (init_left[k] > 0);
        end else begin
            exp_busy[k] = 1'b0;
            if (we && int'(wa) < depth_m[k]) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem_m[k][wa][i*8 +: 8] = wd[i*8 +: 8];
            end
            if (re) begin
                e.data = (int'(ra) < depth_m[k]) ? mem_m[k][ra] : 32'h0;
                e.due  = edge_no + lat_m[k];
                sb[k].push_back(e);
            end
        end
    endtask

    task automatic step(input bit rs, input bit we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input bit re, input logic [3:0] ra);
        @(negedge clk);
        rst_n = rs;
        ifa.wenc = we; ifa.waddr = wa; ifa.wdata = wd; ifa.wbe = be; ifa.renc = re; ifa.raddr = ra;
        ifb.wenc = we; ifb.waddr = wa; ifb.wdata = wd; ifb.wbe = be; ifb.renc = re; ifb.raddr = ra;
        model(0, rs, we, wa, wd, be, re, ra);
        model(1, rs, we, wa, wd, be, re, ra);
    endtask

    task automatic rnd_step(input bit rs);
        step(rs, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom), 4'($urandom),
             1'($urandom_range(0, 1)), 4'($urandom));
    endtask

    task automatic chk(input int k, input logic rv, input logic [31:0] rd, input logic bz);
        exp_t e;
        n_cmp++;
        if (bz !== exp_busy[k]) begin
            n_bad++;
            $display("FAIL init_busy[%0d] edge %0d: got %b want %b", k, edge_no, bz, exp_busy[k]);
        end
        if (rst_n === 1'b0) begin
            n_cmp++;
            if (rv !== 1'b0 || rd !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_out[%0d] edge %0d: got rvalid=%b rdata=%h want 0/0",
                         k, edge_no, rv, rd);
            end
            last_rd[k] = 32'h0;
        end else if (rv === 1'b1) begin
            n_cmp++;
            if (sb[k].size() == 0) begin
                n_bad++;
                $display("FAIL spurious_rvalid[%0d] edge %0d: got rdata=%h want no rvalid",
                         k, edge_no, rd);
            end else begin
                e = sb[k].pop_front();
                if (rd !== e.data || e.due != edge_no) begin
                    n_bad++;
                    $display("FAIL rdata[%0d] edge %0d: got %h want %h (due edge %0d)",
                             k, edge_no, rd, e.data, e.due);
                end
                last_rd[k] = e.data;
            end
        end else begin
            n_cmp++;
            if (rv !== 1'b0 || rd !== last_rd[k]) begin
                n_bad++;
                $display("FAIL hold[%0d] edge %0d: got rvalid=%b rdata=%h want 0/%h",
                         k, edge_no, rv, rd, last_rd[k]);
            end
            if (sb[k].size() > 0) begin
                n_cmp++;
                if (sb[k][0].due <= edge_no) begin
                    n_bad++;
                    $display("FAIL missing_rvalid[%0d] edge %0d: got none want %h",
                             k, edge_no, sb[k][0].data);
                    void'(sb[k].pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk(0, ifa.rvalid, ifa.rdata, busy_a);
            chk(1, ifb.rvalid, ifb.rdata, busy_b);
        end
    end

    initial begin
        rst_n = 1'b0;
        ifa.wenc = 0; ifa.waddr = 0; ifa.wdata = 0; ifa.wbe = 0; ifa.renc = 0; ifa.raddr = 0;
        ifb.wenc = 0; ifb.waddr = 0; ifb.wdata = 0; ifb.wbe = 0; ifb.renc = 0; ifb.raddr = 0;

        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        // requests during the sweep must be ignored
        repeat (16) rnd_step(1);
        for (int a = 0; a < 16; a++) step(1, 0, 0, 0, 0, 1, 4'(a));

        step(1, 1, 4'd3, 32'hAABBCCDD, 4'hF, 0, 0);
        step(1, 1, 4'd3, 32'h00001100, 4'h2, 0, 0);
        step(1, 0, 0, 0, 0, 1, 4'd3);

        step(1, 1, 4'd5, 32'h12345678, 4'h3, 1, 4'd5);
        step(1, 0, 0, 0, 0, 1, 4'd5);

        for (int a = 0; a < 4; a++) step(1, 1, 4'(a), 32'(a + 1), 4'hF, 0, 0);
        for (int a = 0; a < 4; a++) step(1, 0, 0, 0, 0, 1, 4'(a));

        step(1, 1, 4'd13, 32'hDEADBEEF, 4'hF, 1, 4'd13);
        step(1, 0, 0, 0, 0, 1, 4'd13);

        step(1, 1, 4'd7, 32'hCAFEF00D, 4'h0, 1, 4'd7);
        repeat (300) rnd_step(1);

        step(1, 0, 0, 0, 0, 1, 4'd1);
        step(1, 0, 0, 0, 0, 1, 4'd2);
        step(0, 0, 0, 0, 0, 1, 4'd3);
        repeat (16) step(1, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 16; a++) step(1, 0, 0, 0, 0, 1, 4'(a));

        repeat (300) rnd_step(1'($urandom_range(0, 63) != 0));
        repeat (4) step(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;

        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (sb[k].size() != 0) begin
                n_bad++;
                $display("FAIL drain[%0d]: got %0d outstanding reads want 0", k, sb[k].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
